// File: rtl/x1_sram_arbiter.sv
// Arbiter sharing one 8-bit SRAM between the CPU bus and the three-plane GRAM fetcher.
// Round-robin on contention; every SRAM cycle is sequenced by a single FSM.
module x1_sram_arbiter #(
    parameter int unsigned ACC_CYC = 2,
    parameter logic [17:0] GB_BASE = 18'h10000,
    parameter logic [17:0] GR_BASE = 18'h14000,
    parameter logic [17:0] GG_BASE = 18'h18000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_CPU_REQ,
    input  logic        I_CPU_WE,
    input  logic [17:0] I_CPU_A,
    input  logic [7:0]  I_CPU_D,
    output logic [7:0]  O_CPU_D,
    output logic        O_CPU_ACK,
    input  logic        I_VID_REQ,
    input  logic [13:0] I_VID_A,
    output logic [7:0]  O_VID_B,
    output logic [7:0]  O_VID_R,
    output logic [7:0]  O_VID_G,
    output logic        O_VID_VALID,
    output logic        O_VID_MISS,
    output logic [17:0] O_SRAM_A,
    output logic [7:0]  O_SRAM_D,
    input  logic [7:0]  I_SRAM_D,
    output logic        O_SRAM_OE,
    output logic        O_SRAM_WE
);

    typedef enum logic [3:0] {
        IDLE, VID_B, VID_R, VID_G, VID_DONE, CPU_RD, CPU_WR, CPU_REC, CPU_DONE
    } state_t;

    typedef enum logic {LG_CPU, LG_VID} grant_t;

    state_t      state, state_nxt;
    grant_t      last_grant;
    logic [2:0]  cnt;
    logic        vid_pend;
    logic [13:0] vaddr;
    logic [17:0] cpu_a_q;
    logic [7:0]  cpu_d_q;
    logic [7:0]  vb_q, vr_q;

    logic        vid_busy, vid_accept, vid_want, acc_last, arb_en;
    logic        grant_vid, grant_cpu;
    logic [13:0] va_src;
    logic [17:0] ca_src;
    logic [7:0]  cd_src;
    logic [17:0] sram_a_d;
    logic [7:0]  sram_d_d;
    logic        oe_d, we_d;

    // VID_DONE arbitrates like IDLE so a waiting CPU gets the bus with no idle gap
    always_comb begin
        vid_busy   = (state == VID_B) || (state == VID_R) ||
                     (state == VID_G) || (state == VID_DONE);
        vid_accept = I_VID_REQ && !vid_pend && !vid_busy;
        vid_want   = vid_pend || vid_accept;
        acc_last   = (cnt == 3'(ACC_CYC - 1));
        arb_en     = (state == IDLE) || (state == VID_DONE);
        grant_vid  = arb_en && vid_want && (!I_CPU_REQ || last_grant == LG_CPU);
        grant_cpu  = arb_en && I_CPU_REQ && !grant_vid;
        va_src     = vid_accept ? I_VID_A : vaddr;
        ca_src     = grant_cpu ? I_CPU_A : cpu_a_q;
        cd_src     = grant_cpu ? I_CPU_D : cpu_d_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, VID_DONE: begin
                if (grant_vid)
                    state_nxt = VID_B;
                else if (grant_cpu)
                    state_nxt = I_CPU_WE ? CPU_WR : CPU_RD;
                else
                    state_nxt = IDLE;
            end
            VID_B:    if (acc_last) state_nxt = VID_R;
            VID_R:    if (acc_last) state_nxt = VID_G;
            VID_G:    if (acc_last) state_nxt = VID_DONE;
            CPU_RD:   if (acc_last) state_nxt = CPU_DONE;
            CPU_WR:   if (acc_last) state_nxt = CPU_REC;
            CPU_REC:  state_nxt = CPU_DONE;
            CPU_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // SRAM pins are registered from the next state; idle/recovery hold address and data
    always_comb begin
        sram_a_d = O_SRAM_A;
        sram_d_d = O_SRAM_D;
        oe_d     = 1'b0;
        we_d     = 1'b0;
        case (state_nxt)
            VID_B: begin
                sram_a_d = GB_BASE | {4'b0, va_src};
                oe_d     = 1'b1;
            end
            VID_R: begin
                sram_a_d = GR_BASE | {4'b0, va_src};
                oe_d     = 1'b1;
            end
            VID_G: begin
                sram_a_d = GG_BASE | {4'b0, va_src};
                oe_d     = 1'b1;
            end
            CPU_RD: begin
                sram_a_d = ca_src;
                oe_d     = 1'b1;
            end
            CPU_WR: begin
                sram_a_d = ca_src;
                sram_d_d = cd_src;
                we_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state       <= IDLE;
            last_grant  <= LG_CPU;
            cnt         <= '0;
            vid_pend    <= 1'b0;
            vaddr       <= '0;
            cpu_a_q     <= '0;
            cpu_d_q     <= '0;
            vb_q        <= '0;
            vr_q        <= '0;
            O_CPU_D     <= '0;
            O_CPU_ACK   <= 1'b0;
            O_VID_B     <= '0;
            O_VID_R     <= '0;
            O_VID_G     <= '0;
            O_VID_VALID <= 1'b0;
            O_VID_MISS  <= 1'b0;
            O_SRAM_A    <= '0;
            O_SRAM_D    <= '0;
            O_SRAM_OE   <= 1'b0;
            O_SRAM_WE   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 3'd0 : cnt + 3'd1;

            if (grant_vid)
                vid_pend <= 1'b0;
            else if (vid_accept)
                vid_pend <= 1'b1;
            if (vid_accept)
                vaddr <= I_VID_A;
            O_VID_MISS <= I_VID_REQ && !vid_accept;

            if (grant_vid)
                last_grant <= LG_VID;
            else if (grant_cpu)
                last_grant <= LG_CPU;
            if (grant_cpu) begin
                cpu_a_q <= I_CPU_A;
                cpu_d_q <= I_CPU_D;
            end

            if (state == VID_B && acc_last)
                vb_q <= I_SRAM_D;
            if (state == VID_R && acc_last)
                vr_q <= I_SRAM_D;
            // all three planes are published together with the valid strobe
            if (state == VID_G && acc_last) begin
                O_VID_B <= vb_q;
                O_VID_R <= vr_q;
                O_VID_G <= I_SRAM_D;
            end
            O_VID_VALID <= (state_nxt == VID_DONE);

            if (state == CPU_RD && acc_last)
                O_CPU_D <= I_SRAM_D;
            O_CPU_ACK <= (state_nxt == CPU_DONE);

            O_SRAM_A  <= sram_a_d;
            O_SRAM_D  <= sram_d_d;
            O_SRAM_OE <= oe_d;
            O_SRAM_WE <= we_d;
        end
    end

endmodule

// File: tb/tb_x1_sram_arbiter.sv
// Directed bench for x1_sram_arbiter: a transaction-level timeline model predicts every
// cycle's SRAM pins and strobes; literal latency/data checks pin the model down.
module tb_x1_sram_arbiter;

    localparam int unsigned A = 2;
    localparam logic [17:0] GB = 18'h10000;
    localparam logic [17:0] GR = 18'h14000;
    localparam logic [17:0] GG = 18'h18000;
    localparam int N = 4096;

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_CPU_REQ = 1'b0, I_CPU_WE = 1'b0;
    logic [17:0] I_CPU_A = '0;
    logic [7:0]  I_CPU_D = '0;
    logic [7:0]  O_CPU_D;
    logic        O_CPU_ACK;
    logic        I_VID_REQ = 1'b0;
    logic [13:0] I_VID_A = '0;
    logic [7:0]  O_VID_B, O_VID_R, O_VID_G;
    logic        O_VID_VALID, O_VID_MISS;
    logic [17:0] O_SRAM_A;
    logic [7:0]  O_SRAM_D;
    logic [7:0]  I_SRAM_D;
    logic        O_SRAM_OE, O_SRAM_WE;

    x1_sram_arbiter #(.ACC_CYC(A), .GB_BASE(GB), .GR_BASE(GR), .GG_BASE(GG)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET),
        .I_CPU_REQ(I_CPU_REQ), .I_CPU_WE(I_CPU_WE), .I_CPU_A(I_CPU_A), .I_CPU_D(I_CPU_D),
        .O_CPU_D(O_CPU_D), .O_CPU_ACK(O_CPU_ACK),
        .I_VID_REQ(I_VID_REQ), .I_VID_A(I_VID_A),
        .O_VID_B(O_VID_B), .O_VID_R(O_VID_R), .O_VID_G(O_VID_G),
        .O_VID_VALID(O_VID_VALID), .O_VID_MISS(O_VID_MISS),
        .O_SRAM_A(O_SRAM_A), .O_SRAM_D(O_SRAM_D), .I_SRAM_D(I_SRAM_D),
        .O_SRAM_OE(O_SRAM_OE), .O_SRAM_WE(O_SRAM_WE)
    );

    always #5 I_CLK = ~I_CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [17:0] a);
        case (a)
            18'h10123: return 8'hAA;
            18'h14123: return 8'hBB;
            18'h18123: return 8'hCC;
            default:   return 8'(a * 5 + 1);
        endcase
    endfunction

    // external SRAM
    logic [7:0] sram_mem [0:262143];
    bit         sram_wr  [0:262143];
    assign I_SRAM_D = O_SRAM_OE ? (sram_wr[O_SRAM_A] ? sram_mem[O_SRAM_A] : init_val(O_SRAM_A)) : 8'h00;
    always @(posedge I_CLK) begin
        if (O_SRAM_WE) begin
            sram_mem[O_SRAM_A] <= O_SRAM_D;
            sram_wr[O_SRAM_A]  <= 1'b1;
        end
    end

    // reference timeline: entry[n] = expected outputs in the cycle following clock edge n
    typedef struct {
        bit rst, acc, oe, we, chk_d, valid, ack, rd, miss;
        bit [17:0] a;
        bit [7:0] d, b, r, g, cd;
    } exp_t;
    exp_t tl [N];

    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    int  edge_n = 0;
    int  next_arb = 0;
    int  vid_busy_until = 0;
    bit  m_pend = 0, m_last_vid = 0;
    logic [13:0] m_va = '0;

    task automatic sched_vid(input int g, input logic [13:0] va);
        logic [17:0] base [3];
        base[0] = GB; base[1] = GR; base[2] = GG;
        for (int k = 0; k < 3 * int'(A); k++) begin
            tl[g+k].acc = 1; tl[g+k].oe = 1;
            tl[g+k].a   = base[k / int'(A)] + 18'(va);
        end
        tl[g+3*A].valid = 1;
        tl[g+3*A].b = ref_rd(GB + 18'(va));
        tl[g+3*A].r = ref_rd(GR + 18'(va));
        tl[g+3*A].g = ref_rd(GG + 18'(va));
        next_arb = g + 3 * int'(A) + 1;
        vid_busy_until = next_arb;
    endtask

    task automatic sched_cpu(input int g, input bit we, input logic [17:0] ca, input logic [7:0] cd);
        for (int k = 0; k < int'(A); k++) begin
            tl[g+k].acc = 1; tl[g+k].a = ca;
            tl[g+k].oe = !we; tl[g+k].we = we;
            tl[g+k].chk_d = we; tl[g+k].d = cd;
        end
        if (we) begin
            tl[g+A].acc = 1; tl[g+A].a = ca; tl[g+A].chk_d = 1; tl[g+A].d = cd;
            tl[g+A+1].ack = 1;
            ref_mem[int'(ca)] = cd;
            next_arb = g + int'(A) + 3;
        end else begin
            tl[g+A].ack = 1; tl[g+A].rd = 1; tl[g+A].cd = ref_rd(ca);
            next_arb = g + int'(A) + 2;
        end
    endtask

    always @(posedge I_CLK) begin
        bit accept, vwant;
        logic [13:0] va;
        edge_n = edge_n + 1;
        if (edge_n + 3 * int'(A) + 2 < N) begin
            if (I_RESET) begin
                for (int i = edge_n; i < N; i++) tl[i] = '{default: 0};
                tl[edge_n].rst = 1;
                m_pend = 0; m_last_vid = 0;
                next_arb = edge_n + 1;
                vid_busy_until = edge_n;
            end else begin
                accept = I_VID_REQ && !m_pend && (edge_n > vid_busy_until);
                if (I_VID_REQ && !accept) tl[edge_n].miss = 1;
                va = accept ? I_VID_A : m_va;
                if (accept) begin m_va = I_VID_A; m_pend = 1; end
                vwant = m_pend;
                if (edge_n >= next_arb && (vwant || I_CPU_REQ)) begin
                    if (vwant && (!I_CPU_REQ || !m_last_vid)) begin
                        m_pend = 0; m_last_vid = 1;
                        sched_vid(edge_n, va);
                    end else begin
                        m_last_vid = 0;
                        sched_cpu(edge_n, I_CPU_WE, I_CPU_A, I_CPU_D);
                    end
                end
            end
        end
    end

    int valid_seen = 0;
    int miss_seen = 0;

    always @(posedge I_CLK) begin
        int n;
        exp_t e;
        #1;
        n = edge_n;
        if (O_VID_VALID) valid_seen++;
        if (O_VID_MISS) miss_seen++;
        if (n < N) begin
            e = tl[n];
            if (e.rst) begin
                chk("reset_outputs", 64'({O_CPU_D, O_CPU_ACK, O_VID_B, O_VID_R, O_VID_G, O_VID_VALID,
                                          O_VID_MISS, O_SRAM_A, O_SRAM_D, O_SRAM_OE, O_SRAM_WE}), 64'd0);
            end else begin
                chk("strobes{oe,we,valid,ack,miss}",
                    64'({O_SRAM_OE, O_SRAM_WE, O_VID_VALID, O_CPU_ACK, O_VID_MISS}),
                    64'({e.oe, e.we, e.valid, e.ack, e.miss}));
                if (e.acc) chk("sram_addr", 64'(O_SRAM_A), 64'(e.a));
                if (e.chk_d) chk("sram_wdata", 64'(O_SRAM_D), 64'(e.d));
                if (e.valid) chk("vid_brg", 64'({O_VID_B, O_VID_R, O_VID_G}), 64'({e.b, e.r, e.g}));
                if (e.ack && e.rd) chk("cpu_rdata", 64'(O_CPU_D), 64'(e.cd));
            end
        end
    end

    // waits for VALID (sig=0) or ACK (sig=1); lat counts the request cycle as cycle 1
    task automatic await(input int sig, input int maxc, input bit drop_vid, output int lat);
        int c;
        bit hit;
        c = 0; hit = 0; lat = 0;
        while (!hit && c < maxc) begin
            @(posedge I_CLK); #1;
            c++;
            if (drop_vid) I_VID_REQ = 1'b0;
            hit = (sig == 0) ? O_VID_VALID : O_CPU_ACK;
            if (hit && sig == 1) I_CPU_REQ = 1'b0;
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL await_timeout: sig %0d not seen within %0d cycles", sig, maxc);
        end
        lat = c + 1;
    endtask

    task automatic gap();
        repeat (3) @(negedge I_CLK);
    endtask

    initial begin
        int lat, m0, v0, since, maxgap, acks;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, m0, v0, since, maxgap, acks;
        repeat (3) @(negedge I_CLK);
        chk("post_reset_zero", 64'({O_CPU_D, O_CPU_ACK, O_VID_B, O_VID_R, O_VID_G, O_VID_VALID,
                                    O_VID_MISS, O_SRAM_A, O_SRAM_D, O_SRAM_OE, O_SRAM_WE}), 64'd0);
        I_RESET = 1'b0;
        gap();

        // video alone
        I_VID_REQ = 1'b1; I_VID_A = 14'h0123;
        await(0, 20, 1, lat);
        chk("vid_latency", 64'(lat), 64'd8);
        chk("vid_bytes", 64'({O_VID_B, O_VID_R, O_VID_G}), 64'h00AABBCC);
        gap();

        // CPU write then read back
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b1; I_CPU_A = 18'h00456; I_CPU_D = 8'h5A;
        await(1, 20, 0, lat);
        chk("wr_latency", 64'(lat), 64'd5);
        gap();
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b0; I_CPU_A = 18'h00456;
        await(1, 20, 0, lat);
        chk("rd_latency", 64'(lat), 64'd4);
        chk("rd_data", 64'(O_CPU_D), 64'h5A);
        gap();

        // contention straight after reset: video first
        @(negedge I_CLK) I_RESET = 1'b1;
        @(negedge I_CLK) I_RESET = 1'b0;
        I_VID_REQ = 1'b1; I_VID_A = 14'h0200;
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b0; I_CPU_A = 18'h00456;
        await(1, 30, 1, lat);
        chk("contend_cpu_latency", 64'(lat), 64'd11);
        chk("contend_rd_data", 64'(O_CPU_D), 64'h5A);
        gap();
        // a video-only grant, then contention again: CPU wins this time
        I_VID_REQ = 1'b1; I_VID_A = 14'h0123;
        await(0, 20, 1, lat);
        gap();
        I_VID_REQ = 1'b1; I_VID_A = 14'h0123;
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b0; I_CPU_A = 18'h00456;
        await(1, 30, 1, lat);
        chk("rr_cpu_latency", 64'(lat), 64'd4);
        await(0, 20, 0, lat);
        gap();

        // overrun: second request two cycles after the first is dropped
        m0 = miss_seen;
        I_VID_REQ = 1'b1; I_VID_A = 14'h0123;
        @(negedge I_CLK) I_VID_REQ = 1'b0;
        @(negedge I_CLK) begin I_VID_REQ = 1'b1; I_VID_A = 14'h3FFF; end
        await(0, 20, 1, lat);
        chk("overrun_bytes", 64'({O_VID_B, O_VID_R, O_VID_G}), 64'h00AABBCC);
        chk("overrun_miss_count", 64'(miss_seen - m0), 64'd1);
        gap();

        // reset during the first write cycle
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b1; I_CPU_A = 18'h00789; I_CPU_D = 8'h33;
        @(negedge I_CLK) begin I_RESET = 1'b1; I_CPU_REQ = 1'b0; end
        @(posedge I_CLK); #1;
        chk("abort_we", 64'(O_SRAM_WE), 64'd0);
        chk("abort_zero", 64'({O_CPU_D, O_CPU_ACK, O_VID_B, O_VID_R, O_VID_G, O_VID_VALID,
                               O_VID_MISS, O_SRAM_A, O_SRAM_D, O_SRAM_OE, O_SRAM_WE}), 64'd0);
        @(negedge I_CLK) I_RESET = 1'b0;
        gap();
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b0; I_CPU_A = 18'h00456;
        await(1, 20, 0, lat);
        chk("post_abort_rd_latency", 64'(lat), 64'd4);
        chk("post_abort_rd_data", 64'(O_CPU_D), 64'h5A);
        gap();

        // starvation: CPU held, video pulses every 8 cycles
        v0 = valid_seen; since = 0; maxgap = 0; acks = 0;
        I_CPU_REQ = 1'b1; I_CPU_WE = 1'b0; I_CPU_A = 18'h00456; I_VID_A = 14'h0123;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge I_CLK);
            I_VID_REQ = (k % 8 == 0);
            @(posedge I_CLK); #1;
            since++;
            if (O_CPU_ACK) begin
                if (since > maxgap) maxgap = since;
                since = 0;
                acks++;
            end
        end
        @(negedge I_CLK) begin I_CPU_REQ = 1'b0; I_VID_REQ = 1'b0; end
        chk("starve_max_gap_le12", 64'(maxgap <= 12), 64'd1);
        chk("starve_acks_ge4", 64'(acks >= 4), 64'd1);
        chk("starve_valids_ge3", 64'((valid_seen - v0) >= 3), 64'd1);
        repeat (20) @(negedge I_CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/x1_sram_arbiter.md
Name: x1_sram_arbiter

Overview:
- Shares one 8-bit external SRAM between two requesters: the main CPU bus (read/write, 18-bit address) and the video GRAM fetcher (three-plane read bursts, 14-bit address).
- Sits between the CPU bus decode and the SRAM pins, and sequences every SRAM cycle.
- Uses two-requester round-robin arbitration on contention.
- Each video request returns the B, R and G bytes together with a single valid strobe.

Parameters:
- ACC_CYC, 2: SRAM cycles per access, address/OE/WE held; legal range 2..7.
- GB_BASE, 18'h10000: base of the blue GRAM plane; must be 16K-aligned.
- GR_BASE, 18'h14000: base of the red GRAM plane; must be 16K-aligned.
- GG_BASE, 18'h18000: base of the green GRAM plane; must be 16K-aligned.

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  synchronous active-high reset
- I_CPU_REQ  in  1  CPU request, level; held until O_CPU_ACK
- I_CPU_WE  in  1  1 = write, 0 = read; qualified by REQ
- I_CPU_A  in  18  CPU byte address
- I_CPU_D  in  8  CPU write data
- O_CPU_D  out  8  CPU read data; valid when O_CPU_ACK=1 and the access is a read
- O_CPU_ACK  out  1  one-cycle completion pulse
- I_VID_REQ  in  1  one-cycle fetch request pulse
- I_VID_A  in  14  GRAM offset, sampled with I_VID_REQ
- O_VID_B  out  8  blue plane byte
- O_VID_R  out  8  red plane byte
- O_VID_G  out  8  green plane byte
- O_VID_VALID  out  1  one-cycle pulse; B, R and G are all valid
- O_VID_MISS  out  1  one-cycle pulse; a video request was dropped
- O_SRAM_A  out  18  SRAM address
- O_SRAM_D  out  8  SRAM write data
- I_SRAM_D  in  8  SRAM read data
- O_SRAM_OE  out  1  active-high output enable
- O_SRAM_WE  out  1  active-high write enable

Behaviour:
- Reset: state IDLE; vid_pend=0; last_grant=CPU. All outputs are 0, including O_SRAM_A, the data buses and the strobes. Reset asserted mid-access aborts the access at that edge: WE/OE drop, and no ACK or VALID is issued.
- Video capture: I_VID_REQ=1 sets vid_pend and latches I_VID_A.
- Video drop: if vid_pend=1 or a video burst is in progress when I_VID_REQ arrives, the new request is dropped. O_VID_MISS pulses on the next cycle, and the latched address is unchanged.
- States: IDLE, VID_B, VID_R, VID_G, VID_DONE, CPU_RD, CPU_WR, CPU_REC, CPU_DONE. An internal counter cnt runs 0..ACC_CYC-1 inside each access state.
- IDLE grant:
  - Only vid_pend set → VID_B.
  - Only I_CPU_REQ set → CPU_RD or CPU_WR.
  - Both set → the requester not equal to last_grant wins. last_grant updates on every grant.
  - The CPU address and data are registered at grant.
- Address generation: VID_x drives O_SRAM_A = base_x | {4'b0, vaddr}, with OE=1. CPU_RD drives O_SRAM_A = cpu_a, with OE=1. CPU_WR drives O_SRAM_A = cpu_a, O_SRAM_D = cpu_d, WE=1.
- Read sampling: I_SRAM_D is sampled on the edge ending the cnt=ACC_CYC-1 cycle.
  - VID_B → VID_R → VID_G → VID_DONE; vid_pend clears on entry to VID_B.
  - VID_DONE: O_VID_VALID=1, return to IDLE. There is no gap for the CPU between planes.
- CPU_WR → CPU_REC: one cycle, WE=0, address and data held (write recovery). Then CPU_DONE.
- CPU_RD → CPU_DONE. CPU_DONE: O_CPU_ACK=1, with O_CPU_D holding the read byte; return to IDLE.
- CPU handshake: the requester must drop I_CPU_REQ in the cycle after ACK. A REQ still high in IDLE after that cycle is treated as a new request.
- Latency, counted from the cycle a request is first sampled, with the SRAM idle and no contention:
  - Video VALID: 3*ACC_CYC+2 cycles (8 at default).
  - CPU read ACK: ACC_CYC+2 cycles (4).
  - CPU write ACK: ACC_CYC+3 cycles (5).
- Output holding: O_VID_B/R/G and O_CPU_D hold until the next update. OE and WE are never both 1. In IDLE, OE=WE=0 and the address holds its last value.
- Widths: base OR offset; no carry; the offset is zero-extended.

Test Plan:
- Video alone: I_VID_REQ, A=14'h0123; SRAM model holds 10123=AA, 14123=BB, 18123=CC → VALID 8 cycles later with B=AA, R=BB, G=CC. O_SRAM_A sequence is 10123, 14123, 18123, 2 cycles each.
- CPU write then read: write A=18'h00456 D=5A → WE high 2 cycles, recovery cycle, ACK at cycle 5. Read of the same address → ACK at cycle 4 with O_CPU_D=5A.
- Contention: VID_REQ and CPU_REQ in the same cycle after reset → video granted first, CPU ACK at 3*2+1+4=11 cycles. Repeat both together → CPU wins (round-robin).
- Overrun: second I_VID_REQ 2 cycles after the first → O_VID_MISS pulses once; the single VALID carries the first address's data.
- Reset mid-write: I_RESET asserted during CPU_WR cnt=0 → WE=0 the next cycle, no ACK, all outputs 0, state IDLE. A following CPU read completes normally in 4 cycles.
- Starvation: CPU_REQ held while VID_REQ pulses every 8 cycles → grants alternate; the CPU is acked within 12 cycles of every request.
